// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - 4-digit multiplexed seven-segment scanner for the stopwatch BCD count
// Frame-latched digits, adjust-mode pair blinking and pause decimal point, all outputs registered.
module seven_seg_scan #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_digits,
  input  logic        i_adj,
  input  logic        i_sel,
  input  logic        i_pause_state,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [1:0]         idx;
  logic               blink_ph;
  logic [15:0]        shadow;
  logic               load_pend;

  logic               scan_tc;
  logic               blink_tc;
  logic [3:0]         nibble;
  logic               blank;
  logic [3:0]         an_next;
  logic [6:0]         seg_next;
  logic               dp_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  assign scan_tc  = (scan_cnt == SCAN_LAST);
  assign blink_tc = (blink_cnt == BLINK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_tc) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Shadow only changes on the frame wrap so one frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= 16'h0000;
      load_pend <= 1'b1;
    end else if (load_pend) begin
      shadow    <= i_digits;
      load_pend <= 1'b0;
    end else if (scan_tc && (idx == 2'd3)) begin
      shadow <= i_digits;
    end
  end

  // During the load cycle the shadow still holds its reset value, so show the word being loaded.
  always_comb begin
    nibble = load_pend ? i_digits[{idx, 2'b00} +: 4] : shadow[{idx, 2'b00} +: 4];
  end

  always_comb begin
    blank    = i_adj & blink_ph & (i_sel ? ~idx[1] : idx[1]);
    an_next  = blank ? 4'b1111 : ~(4'b0001 << idx);
    seg_next = seg_decode(nibble);
    dp_next  = ~((idx == 2'd2) & i_pause_state & ~blank);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_an  <= 4'b1111;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= an_next;
      o_seg <= seg_next;
      o_dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - self-checking bench for seven_seg_scan
// Elapsed-cycle arithmetic model checked every cycle, plus hand-computed literal vectors.
module tb_seven_seg_scan;

  localparam int SD = 4;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_digits;
  logic        i_adj;
  logic        i_sel;
  logic        i_pause_state;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  seven_seg_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .i_digits(i_digits), .i_adj(i_adj), .i_sel(i_sel),
    .i_pause_state(i_pause_state), .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    dec = (v < 4'd10) ? tbl[v] : 7'h7F;
  endfunction

  // Model: k clocks since release; digit = (k/SD)%4, blink phase = (k/BD)%2.
  int          k;
  logic [15:0] sh;
  logic        first;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; sh = 16'h0; first = 1'b1;
      exp_an = 4'b1111; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      int d, ph;
      logic bl;
      logic [15:0] word;
      d    = (k / SD) % 4;
      ph   = (k / BD) % 2;
      word = first ? i_digits : sh;
      bl   = i_adj && (ph == 1) && (i_sel ? (d < 2) : (d >= 2));
      exp_an  = bl ? 4'b1111 : ~(4'b0001 << d);
      exp_seg = dec(word[d*4 +: 4]);
      exp_dp  = !(d == 2 && i_pause_state && !bl);
      if (first || (k % (4*SD)) == 4*SD - 1) sh = i_digits;
      first = 1'b0;
      k++;
    end
  end

  always @(negedge clk) begin
    vectors++;
    if ({o_an, o_seg, o_dp} !== {exp_an, exp_seg, exp_dp}) begin
      miscompares++;
      $display("FAIL model k=%0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
               k, o_an, o_seg, o_dp, exp_an, exp_seg, exp_dp);
    end
  end

  task automatic lit(input string name, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    vectors++;
    if ({o_an, o_seg, o_dp} !== {an, seg, dp}) begin
      miscompares++;
      $display("FAIL %s n=%0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
               name, n, o_an, o_seg, o_dp, an, seg, dp);
    end
  endtask

  task automatic lit_an_dp(input string name, input logic [3:0] an, input logic dp);
    vectors++;
    if ({o_an, o_dp} !== {an, dp}) begin
      miscompares++;
      $display("FAIL %s n=%0d: an=%b dp=%b, required an=%b dp=%b", name, n, o_an, o_dp, an, dp);
    end
  endtask

  task automatic step_to(input int target);
    while (n < target) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_1234 [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  initial begin
    rst_n = 1'b0; i_digits = 16'h1234; i_adj = 1'b0; i_sel = 1'b0; i_pause_state = 1'b0;
    repeat (3) @(negedge clk);
    lit("reset_state", 4'b1111, 7'h7F, 1'b1);
    rst_n = 1'b1;

    // Scan order over two frames.
    for (int i = 1; i <= 16; i++) begin
      step_to(i);
      lit("scan_order", scan_an[((i-1)/SD)%4], seg_1234[((i-1)/SD)%4], 1'b1);
    end

    // New word mid-frame is held off until the frame wrap.
    step_to(21);
    i_digits = 16'h5678;
    step_to(25); lit("no_tear_d2", 4'b1011, 7'b0100100, 1'b1);
    step_to(29); lit("no_tear_d3", 4'b0111, 7'b1111001, 1'b1);
    step_to(33); lit("new_frame_d0", 4'b1110, 7'b0000000, 1'b1);
    step_to(37); lit("new_frame_d1", 4'b1101, 7'b1111000, 1'b1);
    i_pause_state = 1'b1;
    step_to(41); lit("pause_dp_on", 4'b1011, 7'b0000010, 1'b0);
    step_to(45); lit("pause_dp_off", 4'b0111, 7'b0010010, 1'b1);

    // Blink minutes pair, then seconds pair.
    step_to(48);
    i_adj = 1'b1;
    step_to(53); lit_an_dp("blink_min_d1_on", 4'b1101, 1'b1);
    step_to(57); lit_an_dp("blink_min_d2_off", 4'b1111, 1'b1);
    step_to(64);
    i_sel = 1'b1;
    step_to(73); lit_an_dp("blink_sec_ph0_d2", 4'b1011, 1'b0);
    step_to(81); lit_an_dp("blink_sec_d0_off", 4'b1111, 1'b1);
    step_to(89); lit_an_dp("blink_sec_d2_on", 4'b1011, 1'b0);
    step_to(96);
    i_adj = 1'b0;
    step_to(97); lit_an_dp("blink_end", 4'b1110, 1'b1);

    // Non-BCD nibbles blank every slot.
    i_digits = 16'hABCF;
    i_pause_state = 1'b0;
    step_to(113); lit("nonbcd_d0", 4'b1110, 7'h7F, 1'b1);
    step_to(121); lit("nonbcd_d2", 4'b1011, 7'h7F, 1'b1);
    step_to(125); lit("nonbcd_d3", 4'b0111, 7'h7F, 1'b1);

    // Asynchronous reset between clock edges.
    step_to(130);
    #2;
    rst_n = 1'b0;
    i_digits = 16'h1234;
    #1;
    lit("async_reset", 4'b1111, 7'h7F, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    step_to(1); lit("post_reset_d0", 4'b1110, 7'b0011001, 1'b1);
    step_to(4); lit("post_reset_d0_end", 4'b1110, 7'b0011001, 1'b1);
    step_to(5); lit("post_reset_d1", 4'b1101, 7'b0110000, 1'b1);
    step_to(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
